saikoro_reader: RTL and testbench
=================================

Name: saikoro_reader

Overview:
Receive-side counterpart of the saikoro die. It watches the 7-bit lamp bus and waits for the pattern to stop changing. It then decodes the settled pattern back to a face value 1..6 and hands it out on a valid/ack handshake. It also keeps saturating per-face and total roll counters, used by self-checking benches and the statistics display.

Parameters:
STABLE_CYCLES, 3, consecutive identical samples (after a change) required to declare the die settled; legal range 1..255
CNT_W, 8, width of each face counter and of the total counter

Ports:
ck  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
lamp  input  7  lamp pattern from saikoro (bit0=C, bit1=TL, bit2=TR, bit3=ML, bit4=MR, bit5=BL, bit6=BR)
ack  input  1  consumer accepts the current report; only meaningful while valid=1
valid  output  1  report pending (value/err stable while high)
value  output  3  decoded face 1..6; 0 when err=1
err  output  1  settled pattern was not a legal face
overrun  output  1  lamp changed while a report was pending; cleared by ack
hist_sel  input  3  face select 1..6 for hist_cnt
hist_cnt  output  CNT_W  count for face hist_sel; 0 for sel 0 or 7 (combinational read)
total_cnt  output  CNT_W  number of legal reports; saturating

Behaviour:
- Reset state:
  - All outputs 0; counters 0; lamp_q=0; stab_cnt=0.
  - FSM=ARMED.
  - Reset has priority over everything, including mid-report; a pending report is discarded.
- Legal patterns (hex):
  - 1=01, 2=42, 3=43, 4=66, 5=67, 6=7E.
  - Every other value, including 00, is illegal.
- Sampling:
  - Every edge lamp_q<=lamp.
  - stab_cnt<=0 if lamp!=lamp_q; otherwise it increments, saturating at STABLE_CYCLES.
  - "change" = lamp!=lamp_q on an edge.
- settle event = lamp==lamp_q and stab_cnt==STABLE_CYCLES-1 on an edge.
- Latency: if pattern P is first sampled at edge e0 and held, valid is high after edge e0+STABLE_CYCLES.
- FSM:
  - ARMED: on settle -> REPORT.
    - Legal P: value<=face, err<=0, hist[face]++ and total++ (both saturate at all-ones).
    - Illegal P: value<=0, err<=1, no counter update.
  - REPORT: valid=1; value and err held.
    - A change while in REPORT sets overrun and a sticky "changed" flag.
    - On ack: valid, err and overrun cleared. Next state is ARMED if changed was set or a change occurs on the ack edge; otherwise DISARMED.
    - A settle in REPORT is ignored; at most one report per settle.
  - DISARMED: on change -> ARMED. Same pattern held forever produces no further reports.
- ack while valid=0 is ignored.
- Simultaneous ack and change on the same edge: ack completes, the change is counted, next state is ARMED, and overrun is not set.
- Counter saturation: a face at 2^CNT_W-1 stays there; total saturates independently.
- After reset lamp_q=0, so any nonzero lamp held STABLE_CYCLES cycles produces a first report. lamp held at 00 yields err.

Decomposition:
- Shared package saikoro_pkg:
  - face pattern constants PAT_1..PAT_6.
  - reader FSM state encoding (ARMED, REPORT, DISARMED).
  - function face_of(pattern) returning 0..6 (0=illegal). The saikoro encoder is expected to use the same constants.
- One natural sub-module: saikoro_settle_det, containing lamp_q, stab_cnt, and the change/settle outputs, parameterised by STABLE_CYCLES.
- Decode, FSM and counters stay in the top.

Test Plan:
- Reset, then lamp=43 held, ack=0 -> valid=1 three cycles after first sample; value=3, err=0, total_cnt=1; hist_sel=3 gives 1.
- Rolling: lamp cycles 01,42,43,66,67,7E every clock for 10 clocks, then holds 66 -> no valid during rolling; one report value=4; ack -> valid=0; holding 66 another 20 clocks gives no new report.
- Illegal settle: lamp=55 held -> valid=1, err=1, value=0, total_cnt unchanged; ack clears err.
- Overrun: report 7E pending, lamp changes to 01 and settles before ack -> overrun=1 and valid still shows 6. After ack, overrun=0 and the next settle of 01 reports 1.
- Simultaneous ack+change on the same edge -> overrun stays 0; the new pattern is reported after STABLE_CYCLES.
- Saturation/reset: CNT_W=2, four reports of face 2 -> hist_cnt=3. Reset asserted while valid=1 -> next cycle valid=0, all counters 0.

Source files
------------

// File: rtl/saikoro_pkg.sv
// Shared saikoro definitions: lamp patterns for each face, the reader FSM
// states, and the pattern-to-face decoder.
package saikoro_pkg;

  localparam logic [6:0] PAT_1 = 7'h01;
  localparam logic [6:0] PAT_2 = 7'h42;
  localparam logic [6:0] PAT_3 = 7'h43;
  localparam logic [6:0] PAT_4 = 7'h66;
  localparam logic [6:0] PAT_5 = 7'h67;
  localparam logic [6:0] PAT_6 = 7'h7E;

  typedef enum logic [1:0] {
    ARMED    = 2'd0,
    REPORT   = 2'd1,
    DISARMED = 2'd2
  } reader_state_e;

  // Returns 1..6 for a legal face pattern, 0 for anything else (including 00).
  function automatic logic [2:0] face_of(input logic [6:0] pattern);
    case (pattern)
      PAT_1:   return 3'd1;
      PAT_2:   return 3'd2;
      PAT_3:   return 3'd3;
      PAT_4:   return 3'd4;
      PAT_5:   return 3'd5;
      PAT_6:   return 3'd6;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/saikoro_settle_det.sv
// Lamp-bus stability detector: flags every change and a single settle pulse
// once a pattern has been held for STABLE_CYCLES consecutive samples.
module saikoro_settle_det #(
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic       ck,
  input  logic       reset,
  input  logic [6:0] lamp,
  output logic       change,
  output logic       settle
);

  localparam logic [7:0] STAB_SAT  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STAB_LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0] lamp_q;
  logic [7:0] stab_cnt;

  assign change = (lamp != lamp_q);
  // Saturating at STABLE_CYCLES makes settle a one-shot per held pattern.
  assign settle = !change && (stab_cnt == STAB_LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ck) begin
    if (reset) begin
      lamp_q   <= '0;
      stab_cnt <= '0;
    end else begin
      lamp_q <= lamp;
      if (change)
        stab_cnt <= '0;
      else if (stab_cnt != STAB_SAT)
        stab_cnt <= stab_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/saikoro_reader.sv
// Receive side of the saikoro die: waits for the lamp bus to settle, decodes
// the face, reports it on valid/ack and keeps saturating roll statistics.
module saikoro_reader
  import saikoro_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             ck,
  input  logic             reset,
  input  logic [6:0]       lamp,
  input  logic             ack,
  output logic             valid,
  output logic [2:0]       value,
  output logic             err,
  output logic             overrun,
  input  logic [2:0]       hist_sel,
  output logic [CNT_W-1:0] hist_cnt,
  output logic [CNT_W-1:0] total_cnt
);

  reader_state_e    state, state_next;
  logic             change, settle, changed;
  logic [2:0]       face;
  logic [CNT_W-1:0] hist [6];

  saikoro_settle_det #(.STABLE_CYCLES(STABLE_CYCLES)) u_settle (
    .ck     (ck),
    .reset  (reset),
    .lamp   (lamp),
    .change (change),
    .settle (settle)
  );

  // On a settle edge lamp equals lamp_q, so decoding the live bus is safe.
  assign face  = face_of(lamp);
  assign valid = (state == REPORT);

  always_ff @(posedge ck) begin
    if (reset) state <= ARMED;
    else       state <= state_next;
  end

  // NOTE: next state is defaulted first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ARMED:    if (settle) state_next = REPORT;
      REPORT:   if (ack)    state_next = (changed || change) ? ARMED : DISARMED;
      DISARMED: if (change) state_next = ARMED;
      default:  state_next = ARMED;
    endcase
  end

  // A change on the ack edge belongs to the next round, so it never raises overrun.
  always_ff @(posedge ck) begin
    if (reset) begin
      value   <= '0;
      err     <= 1'b0;
      overrun <= 1'b0;
      changed <= 1'b0;
    end else if (state == ARMED && settle) begin
      value <= face;
      err   <= (face == 3'd0);
    end else if (state == REPORT) begin
      if (ack) begin
        err     <= 1'b0;
        overrun <= 1'b0;
        changed <= 1'b0;
      end else if (change) begin
        overrun <= 1'b1;
        changed <= 1'b1;
      end
    end
  end

  // NOTE: the histogram is a register array, not RAM, because reset must
  // zero every entry synchronously.
  always_ff @(posedge ck) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) hist[i] <= '0;
      total_cnt <= '0;
    end else if (state == ARMED && settle && face != 3'd0) begin
      for (int i = 0; i < 6; i++)
        if (face == 3'(i + 1) && hist[i] != '1) hist[i] <= hist[i] + CNT_W'(1);
      if (total_cnt != '1) total_cnt <= total_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    case (hist_sel)
      3'd1:    hist_cnt = hist[0];
      3'd2:    hist_cnt = hist[1];
      3'd3:    hist_cnt = hist[2];
      3'd4:    hist_cnt = hist[3];
      3'd5:    hist_cnt = hist[4];
      3'd6:    hist_cnt = hist[5];
      default: hist_cnt = '0;
    endcase
  end

endmodule

// File: tb/tb_saikoro_reader.sv
// Directed bench for saikoro_reader: main instance (CNT_W=8) covers the
// report flow; a CNT_W=2 instance covers saturation and reset mid-report.
module tb_saikoro_reader;

  logic       ck = 1'b0;
  logic       reset, ack;
  logic [6:0] lamp;
  logic [2:0] hist_sel;
  logic       valid, err, overrun;
  logic [2:0] value;
  logic [7:0] hist_cnt, total_cnt;

  logic       reset1, ack1;
  logic [6:0] lamp1;
  logic       valid1, err1, overrun1;
  logic [2:0] value1;
  logic [1:0] hist_cnt1, total_cnt1;

  int checks = 0;
  int errors = 0;
  logic [6:0] roll [6] = '{7'h01, 7'h42, 7'h43, 7'h66, 7'h67, 7'h7E};
  logic seen_valid;

  always #5 ck = ~ck;

  saikoro_reader #(.STABLE_CYCLES(3), .CNT_W(8)) dut (
    .ck(ck), .reset(reset), .lamp(lamp), .ack(ack),
    .valid(valid), .value(value), .err(err), .overrun(overrun),
    .hist_sel(hist_sel), .hist_cnt(hist_cnt), .total_cnt(total_cnt)
  );

  saikoro_reader #(.STABLE_CYCLES(3), .CNT_W(2)) dut_sat (
    .ck(ck), .reset(reset1), .lamp(lamp1), .ack(ack1),
    .valid(valid1), .value(value1), .err(err1), .overrun(overrun1),
    .hist_sel(3'd2), .hist_cnt(hist_cnt1), .total_cnt(total_cnt1)
  );

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b1; ack = 1'b0; lamp = 7'h00; hist_sel = 3'd3;
    reset1 = 1'b1; ack1 = 1'b0; lamp1 = 7'h00;
    ticks(2);
    check("rst_valid",   valid,     0);
    check("rst_value",   value,     0);
    check("rst_err",     err,       0);
    check("rst_overrun", overrun,   0);
    check("rst_total",   total_cnt, 0);
    check("rst_hist3",   hist_cnt,  0);

    // First report: 43 sampled at e0, valid after e0+3.
    reset = 1'b0; lamp = 7'h43;
    tick();
    check("first_e0_valid", valid, 0);
    ticks(2);
    check("first_e2_valid", valid, 0);
    tick();
    check("first_valid", valid,     1);
    check("first_value", value,     3);
    check("first_err",   err,       0);
    check("first_total", total_cnt, 1);
    check("first_hist3", hist_cnt,  1);
    ticks(3);
    check("first_hold_valid", valid,     1);
    check("first_hold_total", total_cnt, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("first_ack_valid", valid, 0);

    // Rolling: no report while the bus keeps changing; last rolled face is 66.
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      lamp = roll[i % 6];
      tick();
      seen_valid |= valid;
    end
    check("roll_no_valid", seen_valid, 0);
    lamp = 7'h66;
    ticks(2);
    check("roll_e2_valid", valid, 0);
    tick();
    check("roll_valid", valid, 1);
    check("roll_value", value, 4);
    ack = 1'b1; tick(); ack = 1'b0;
    check("roll_ack_valid", valid, 0);
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_valid |= valid;
    end
    check("roll_hold_no_report", seen_valid, 0);
    check("roll_total", total_cnt, 2);
    hist_sel = 3'd4; #1;
    check("roll_hist4", hist_cnt, 1);

    // Illegal pattern.
    lamp = 7'h55;
    ticks(4);
    check("ill_valid", valid,     1);
    check("ill_err",   err,       1);
    check("ill_value", value,     0);
    check("ill_total", total_cnt, 2);
    ack = 1'b1; tick(); ack = 1'b0;
    check("ill_ack_err",   err,   0);
    check("ill_ack_valid", valid, 0);

    // Overrun: 7E pending, bus moves to 01 and settles before ack.
    lamp = 7'h7E;
    ticks(4);
    check("ovr_valid6", value, 6);
    lamp = 7'h01;
    tick();
    check("ovr_set",   overrun, 1);
    check("ovr_valid", valid,   1);
    ticks(3);
    check("ovr_hold_value",   value,   6);
    check("ovr_hold_overrun", overrun, 1);
    ack = 1'b1; tick(); ack = 1'b0;
    check("ovr_ack_overrun", overrun, 0);
    check("ovr_ack_valid",   valid,   0);
    lamp = 7'h00; tick();
    lamp = 7'h01;
    ticks(4);
    check("ovr_next_valid", valid, 1);
    check("ovr_next_value", value, 1);
    check("ovr_total",      total_cnt, 4);

    // Ack and change on the same edge.
    ack = 1'b1; lamp = 7'h42;
    tick();
    ack = 1'b0;
    check("sim_valid",   valid,   0);
    check("sim_overrun", overrun, 0);
    ticks(2);
    check("sim_e2_valid", valid, 0);
    tick();
    check("sim_valid2",  valid,   1);
    check("sim_value",   value,   2);
    check("sim_overrun2", overrun, 0);
    check("sim_total",   total_cnt, 5);
    hist_sel = 3'd0; #1;
    check("hist_sel0", hist_cnt, 0);
    hist_sel = 3'd7; #1;
    check("hist_sel7", hist_cnt, 0);
    hist_sel = 3'd6; #1;
    check("hist_sel6", hist_cnt, 1);
    ack = 1'b1; tick(); ack = 1'b0;

    // CNT_W=2 instance: four reports of face 2 saturate at 3.
    reset1 = 1'b0;
    for (int r = 0; r < 4; r++) begin
      lamp1 = 7'h00; tick();
      lamp1 = 7'h42; ticks(4);
      check("sat_valid", valid1, 1);
      check("sat_value", value1, 2);
      ack1 = 1'b1; tick(); ack1 = 1'b0;
    end
    check("sat_hist2", hist_cnt1,  3);
    check("sat_total", total_cnt1, 3);
    lamp1 = 7'h00; tick();
    lamp1 = 7'h42; ticks(4);
    check("sat_pre_rst_valid", valid1, 1);
    reset1 = 1'b1; tick();
    check("sat_rst_valid", valid1,     0);
    check("sat_rst_value", value1,     0);
    check("sat_rst_hist",  hist_cnt1,  0);
    check("sat_rst_total", total_cnt1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
